// File: rtl/tmr_hw_ctrl.sv
// tmr_hw_ctrl: timer engine that sits beside the timer SFR bank.
// Runs a prescaled up-counter with period match and produces the SFR
// hardware-update / value buses plus a one-cycle match interrupt.
// Every output is registered and lags the internal state/counter change
// that causes it by one sfr_clk.
//
// Ports:
//   sfr_clk        clock shared with the SFR bank
//   sys_rst_n      asynchronous active-low reset
//   tmr_ctrl       TMRCTRL: [0] EN, [1] MODE (1 = one-shot), [2 +: PRESC_WIDTH] PRESC
//   tmr_period     TMRPER: low CNT_WIDTH bits are the match value
//   cnt_hw_update  TMRCNT update mask (low CNT_WIDTH bits, one cycle after cnt moves)
//   cnt_hw_value   TMRCNT mirror value (cnt, zero-extended)
//   stat_hw_update TMRSTAT update mask: [0] OVF on match, [1] RUN always
//   stat_hw_value  TMRSTAT value: [0] OVF set, [1] RUN status
//   ctrl_hw_update TMRCTRL update mask: [0] EN auto-clear on one-shot completion
//   ctrl_hw_value  TMRCTRL value (always 0: clears EN)
//   tmr_irq        one-cycle match pulse
//
// Build option: define TMR_ONESHOT_EN to honour MODE (DONE state and EN
// auto-clear). Without it the timer is always continuous and the ctrl
// buses are tied to 0.
module tmr_hw_ctrl #(
  parameter int unsigned SFR_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                 sfr_clk,
  input  logic                 sys_rst_n,
  input  logic [SFR_WIDTH-1:0] tmr_ctrl,
  input  logic [SFR_WIDTH-1:0] tmr_period,
  output logic [SFR_WIDTH-1:0] cnt_hw_update,
  output logic [SFR_WIDTH-1:0] cnt_hw_value,
  output logic [SFR_WIDTH-1:0] stat_hw_update,
  output logic [SFR_WIDTH-1:0] stat_hw_value,
  output logic [SFR_WIDTH-1:0] ctrl_hw_update,
  output logic [SFR_WIDTH-1:0] ctrl_hw_value,
  output logic                 tmr_irq
);

`ifdef TMR_ONESHOT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1} state_e;
`endif

  state_e                 state_q, state_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   match_c, done_ent_c;

  // Event flags captured at the edge where state/counter change.
  logic                   chg_q, match_q, done_ent_q;
  // Output registers.
  logic                   cnt_upd_q, irq_q, run_q, run_upd_q;
  logic [CNT_WIDTH-1:0]   cnt_val_q;

  logic                   en_c;
  logic [PRESC_WIDTH-1:0] presc_c;
  logic [CNT_WIDTH-1:0]   period_c;
  logic                   unused_c;

  assign en_c     = tmr_ctrl[0];
  assign presc_c  = tmr_ctrl[2 +: PRESC_WIDTH];
  assign period_c = tmr_period[CNT_WIDTH-1:0];
  // Reserved SFR bits are intentionally ignored.
  assign unused_c = ^{tmr_ctrl, tmr_period};

  // State, prescaler and counter registers.
  always_ff @(posedge sfr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      cnt_q      <= '0;
      chg_q      <= 1'b0;
      match_q    <= 1'b0;
      done_ent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      chg_q      <= (cnt_d != cnt_q);
      match_q    <= match_c;
      done_ent_q <= done_ent_c;
    end
  end

  // Next state, prescaler tick and counter/match. Counting happens only while
  // RUN and EN are both high, so dropping EN freezes presc/cnt (pause).
  // Dropping EN wins over a same-cycle one-shot match.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    match_c    = 1'b0;
    done_ent_c = 1'b0;

    if ((state_q == ST_RUN) && en_c) begin
      // presc_q above a lowered PRESC simply wraps through all-ones.
      if (presc_q == presc_c) begin
        presc_d = '0;
        if (cnt_q == period_c) begin
          cnt_d   = '0;
          match_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end else begin
        presc_d = presc_q + PRESC_WIDTH'(1);
      end
    end

    case (state_q)
      ST_IDLE: if (en_c) state_d = ST_RUN;
      ST_RUN: begin
        if (!en_c) begin
          state_d = ST_IDLE;
`ifdef TMR_ONESHOT_EN
        end else if (match_c && tmr_ctrl[1]) begin
          state_d    = ST_DONE;
          done_ent_c = 1'b1;
`endif
        end
      end
`ifdef TMR_ONESHOT_EN
      // Leave DONE only once the auto-cleared EN is seen low.
      ST_DONE: if (!en_c) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers, one cycle behind the internal change.
  always_ff @(posedge sfr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_upd_q <= 1'b0;
      cnt_val_q <= '0;
      irq_q     <= 1'b0;
      run_q     <= 1'b0;
      run_upd_q <= 1'b0;
    end else begin
      cnt_upd_q <= chg_q;
      cnt_val_q <= cnt_q;
      irq_q     <= match_q;
      run_q     <= (state_q == ST_RUN);
      run_upd_q <= 1'b1;
    end
  end

`ifdef TMR_ONESHOT_EN
  logic en_clr_q;

  // EN auto-clear pulse on DONE entry.
  always_ff @(posedge sfr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) en_clr_q <= 1'b0;
    else            en_clr_q <= done_ent_q;
  end

  assign ctrl_hw_update = SFR_WIDTH'(en_clr_q);
`else
  logic unused_done_c;
  assign unused_done_c  = done_ent_q;
  assign ctrl_hw_update = '0;
`endif
  assign ctrl_hw_value  = '0;

  assign cnt_hw_update  = SFR_WIDTH'({CNT_WIDTH{cnt_upd_q}});
  assign cnt_hw_value   = SFR_WIDTH'(cnt_val_q);
  assign stat_hw_update = SFR_WIDTH'({run_upd_q, irq_q});
  assign stat_hw_value  = SFR_WIDTH'({run_q, irq_q});
  assign tmr_irq        = irq_q;

endmodule

// File: tb/tb_tmr_hw_ctrl.sv
// Self-checking bench for tmr_hw_ctrl (32-bit SFR/counter, 8-bit prescaler).
// A behavioural timer model predicts the output buses one cycle after each
// modelled counter/state event; the SFR bank's EN auto-clear is emulated.
module tb_tmr_hw_ctrl;
  localparam int unsigned W = 32;

  logic         sfr_clk = 1'b0;
  logic         sys_rst_n;
  logic [W-1:0] tmr_ctrl, tmr_period;
  logic [W-1:0] cnt_hw_update, cnt_hw_value, stat_hw_update, stat_hw_value;
  logic [W-1:0] ctrl_hw_update, ctrl_hw_value;
  logic         tmr_irq;

  always #5 sfr_clk = ~sfr_clk;

  tmr_hw_ctrl #(.SFR_WIDTH(W), .CNT_WIDTH(W), .PRESC_WIDTH(8)) dut (
    .sfr_clk(sfr_clk), .sys_rst_n(sys_rst_n),
    .tmr_ctrl(tmr_ctrl), .tmr_period(tmr_period),
    .cnt_hw_update(cnt_hw_update), .cnt_hw_value(cnt_hw_value),
    .stat_hw_update(stat_hw_update), .stat_hw_value(stat_hw_value),
    .ctrl_hw_update(ctrl_hw_update), .ctrl_hw_value(ctrl_hw_value),
    .tmr_irq(tmr_irq)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model: is the timer counting/finished, prescale and count values.
  bit          m_run, m_done;
  int unsigned m_presc, m_cnt;
  // Events of the most recent edge, which become visible after the next one.
  bit          p_match, p_chg, p_done;
  // Expected outputs after the current edge.
  bit          e_irq, e_cupd, e_run, e_runupd, e_ctrl;
  int unsigned e_cval;

  logic [192:0] exp_v, obs_v;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_presc = 0; m_cnt = 0;
    p_match = 0; p_chg = 0; p_done = 0;
    e_irq = 0; e_cupd = 0; e_run = 0; e_runupd = 0; e_ctrl = 0; e_cval = 0;
  endtask

  task automatic model_edge();
    bit en, os, match, chg, entered;
    int unsigned presc, per, old;
    en    = tmr_ctrl[0];
`ifdef TMR_ONESHOT_EN
    os    = tmr_ctrl[1];
`else
    os    = 1'b0;
`endif
    presc = int'(tmr_ctrl[9:2]);
    per   = tmr_period;
    // What happened at the previous edge shows up now.
    e_irq = p_match; e_cupd = p_chg; e_cval = m_cnt; e_run = m_run;
    e_ctrl = p_done; e_runupd = 1;
    match = 0; chg = 0; entered = 0;
    if (m_run) begin
      if (en) begin
        if (m_presc == presc) begin
          m_presc = 0;
          old = m_cnt;
          if (m_cnt == per) begin m_cnt = 0; match = 1; end
          else m_cnt = m_cnt + 1;
          chg = (m_cnt != old);
        end else begin
          m_presc = (m_presc + 1) % 256;
        end
        if (match && os) begin m_run = 0; m_done = 1; entered = 1; end
      end else begin
        m_run = 0;
      end
    end else if (m_done) begin
      if (!en) m_done = 0;
    end else if (en) begin
      m_run = 1;
    end
    p_match = match; p_chg = chg; p_done = entered;
  endtask

  // Advance one clock: model update, SFR EN auto-clear emulation, sample at +1.
  task automatic step();
    bit clr;
    clr = ctrl_hw_update[0] & ~ctrl_hw_value[0];
    @(posedge sfr_clk);
    if (!sys_rst_n) model_reset();
    else model_edge();
    if (clr && sys_rst_n) tmr_ctrl[0] = 1'b0;
    #1;
    cyc++;
    exp_v = {e_irq, {32{e_cupd}}, (e_cupd ? e_cval : 32'd0),
             {30'd0, e_runupd, e_irq}, {30'd0, e_run, e_irq}, {31'd0, e_ctrl}, 32'd0};
    obs_v = {tmr_irq, cnt_hw_update, (e_cupd ? cnt_hw_value : 32'd0),
             stat_hw_update, stat_hw_value, ctrl_hw_update, ctrl_hw_value};
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    tmr_ctrl = '0;
    tmr_period = '0;
    step();
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int irqs;
    sys_rst_n = 1'b0;
    model_reset();
    tmr_ctrl = '0;
    tmr_period = '0;
    step();
    n_chk++;
    if (obs_v !== 193'd0) $display("FAIL reset_state cyc=%0d got=%h exp=0", cyc, obs_v);
    else n_pass++;
    sys_rst_n = 1'b1;
    irqs = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tmr_irq) irqs++;
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_chk++;
    if (stat_hw_update !== 32'd2 || stat_hw_value !== 32'd0 || irqs != 0)
      $display("FAIL idle_stat got upd=%h val=%h irqs=%0d exp upd=2 val=0 irqs=0",
               stat_hw_update, stat_hw_value, irqs);
    else n_pass++;
  endtask

  task automatic test_continuous();
    int unsigned seen[$];
    do_reset();
    tmr_ctrl = 32'h1;
    tmr_period = 32'd3;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cnt_hw_update[0]) seen.push_back(cnt_hw_value);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL continuous cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_chk++;
    if (seen.size() < 5 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3 || seen[3] != 0 || seen[4] != 1)
      $display("FAIL cont_seq got size=%0d first=%0d exp 1,2,3,0,1", seen.size(),
               (seen.size() > 0) ? seen[0] : 0);
    else n_pass++;
  endtask

  task automatic test_prescale();
    int last_irq, gap, bad;
    do_reset();
    tmr_ctrl = {22'd0, 8'd2, 1'b0, 1'b1};
    tmr_period = 32'd1;
    last_irq = -1; bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tmr_irq) begin
        gap = i - last_irq;
        if (last_irq >= 0 && gap != 6) bad++;
        last_irq = i;
      end
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL prescale cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_chk++;
    if (bad != 0 || last_irq < 0) $display("FAIL presc_gap got bad_gaps=%0d last=%0d exp 0 bad", bad, last_irq);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    int irqs, clrs;
    do_reset();
    tmr_ctrl = 32'h3;
    tmr_period = 32'd5;
    irqs = 0; clrs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tmr_irq) irqs++;
      if (ctrl_hw_update[0]) clrs++;
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL oneshot cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_chk++;
`ifdef TMR_ONESHOT_EN
    if (irqs != 1 || clrs != 1 || stat_hw_value[1] !== 1'b0)
      $display("FAIL oneshot_count got irqs=%0d clrs=%0d run=%b exp 1 1 0", irqs, clrs, stat_hw_value[1]);
    else n_pass++;
`else
    if (irqs < 2 || clrs != 0)
      $display("FAIL mode_ignored got irqs=%0d clrs=%0d exp >=2 and 0", irqs, clrs);
    else n_pass++;
`endif
  endtask

  task automatic test_pause();
    int guard;
    bit got;
    do_reset();
    tmr_ctrl = 32'h1;
    tmr_period = 32'd9;
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin step(); guard++; end
    tmr_ctrl[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL pause cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    tmr_ctrl[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (cnt_hw_update[0]) begin
        got = 1;
        n_chk++;
        if (cnt_hw_value !== 32'd3) $display("FAIL resume got=%0d exp=3", cnt_hw_value);
        else n_pass++;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL resume_timeout got no update exp cnt=3");
    end
  endtask

  task automatic test_period_zero();
    int upds, irqs;
    do_reset();
    tmr_ctrl = 32'h1;
    tmr_period = 32'd0;
    upds = 0; irqs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cnt_hw_update != 0) upds++;
      if (tmr_irq) irqs++;
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL period0 cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_chk++;
    if (upds != 0 || irqs < 15) $display("FAIL period0_counts got upds=%0d irqs=%0d exp 0 and >=15", upds, irqs);
    else n_pass++;
    // Asynchronous reset between clock edges.
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({tmr_irq, cnt_hw_update, cnt_hw_value, stat_hw_update, stat_hw_value,
         ctrl_hw_update, ctrl_hw_value} !== 193'd0)
      $display("FAIL async_reset got irq=%b stat_upd=%h exp all 0", tmr_irq, stat_hw_update);
    else n_pass++;
    model_reset();
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    tmr_ctrl = 32'h1;
    tmr_period = 32'd4;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) tmr_ctrl[0] = ~tmr_ctrl[0];
      if ($urandom_range(31) == 0) tmr_ctrl[1] = 1'($urandom_range(1));
      if ($urandom_range(31) == 0) tmr_ctrl[9:2] = 8'($urandom_range(3));
      if ($urandom_range(31) == 0) tmr_period = $urandom_range(7);
      step();
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    tmr_ctrl = '0;
    tmr_period = '0;
    model_reset();
    test_reset();
    test_continuous();
    test_prescale();
    test_oneshot();
    test_pause();
    test_period_zero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
